// File: rtl/read_intr_receiver_pkg.sv
// Shared definitions for the PL read-interrupt handshake: receiver FSM encoding
// and the default pulse-stretch timing that source and receiver must agree on.
package read_intr_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH_CHK = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_LOW_CHK  = 2'd3
  } state_e;

  localparam int DEF_MIN_HIGH = 8;
  localparam int DEF_MIN_LOW  = 8;

endpackage

// File: rtl/read_intr_receiver_intr_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
module intr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/read_intr_receiver.sv
// Receives a stretched interrupt level, deglitches it into one event per
// assertion, and queues events in a saturating pending counter.
module read_intr_receiver
  import read_intr_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = DEF_MIN_HIGH,
  parameter int MIN_LOW     = DEF_MIN_LOW,
  parameter int CNT_WIDTH   = 15,
  parameter int PEND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  intr_in,
  input  logic                  evt_ack,
  input  logic                  ovf_clr,
  output logic                  evt_pulse,
  output logic                  evt_valid,
  output logic [PEND_WIDTH-1:0] pend_cnt,
  output logic                  overflow,
  output logic                  err_short
);

  localparam logic [CNT_WIDTH-1:0]  HIGH_LAST = CNT_WIDTH'(MIN_HIGH - 1);
  localparam logic [CNT_WIDTH-1:0]  LOW_LAST  = CNT_WIDTH'(MIN_LOW - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

  logic                  s;
  state_e                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  accept;
  logic                  ack;
  logic                  ovf_set;
  logic [PEND_WIDTH-1:0] pend_next;

  intr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (intr_in),
    .q     (s)
  );

  assign accept = (state == ST_HIGH_CHK) && s && (cnt >= HIGH_LAST);
  assign ack    = evt_ack && (pend_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      evt_pulse <= 1'b0;
      err_short <= 1'b0;
    end else begin
      evt_pulse <= 1'b0;
      err_short <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= s ? CNT_WIDTH'(1) : '0;
          if (s) state <= ST_HIGH_CHK;
        end
        ST_HIGH_CHK: begin
          if (!s) begin
            err_short <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
          end else if (accept) begin
            evt_pulse <= 1'b1;
            state     <= ST_WAIT_LOW;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A level held high stays here, so it yields only one event.
        ST_WAIT_LOW: begin
          if (!s) begin
            state <= ST_LOW_CHK;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        ST_LOW_CHK: begin
          if (s) begin
            state <= ST_WAIT_LOW;
            cnt   <= '0;
          end else if (cnt >= LOW_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    pend_next = pend_cnt;
    ovf_set   = 1'b0;
    if (accept && !ack) begin
      if (pend_cnt == PEND_MAX) ovf_set   = 1'b1;
      else                      pend_next = pend_cnt + 1'b1;
    end else if (ack && !accept) begin
      pend_next = pend_cnt - 1'b1;
    end
  end

  // A simultaneous accept and ack cancel out, even when the counter is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_cnt  <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pend_cnt  <= pend_next;
      evt_valid <= (pend_next != '0);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_intr_receiver.sv
// Directed bench for read_intr_receiver: default instance plus a PEND_WIDTH=2
// instance for saturation and overflow.
module tb_read_intr_receiver;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       intr_in, evt_ack, ovf_clr, evt_ack2, ovf_clr2;
  logic       evt_pulse, evt_valid, overflow, err_short;
  logic [3:0] pend_cnt;
  logic       evt_pulse2, evt_valid2, overflow2, err_short2;
  logic [1:0] pend_cnt2;

  int checks = 0;
  int errors = 0;
  int n_pulse, pulse_edge, n_err;

  always #5 clk = ~clk;

  read_intr_receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .intr_in   (intr_in),
    .evt_ack   (evt_ack),
    .ovf_clr   (ovf_clr),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .pend_cnt  (pend_cnt),
    .overflow  (overflow),
    .err_short (err_short)
  );

  read_intr_receiver #(.PEND_WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst2_n),
    .intr_in   (intr_in),
    .evt_ack   (evt_ack2),
    .ovf_clr   (ovf_clr2),
    .evt_pulse (evt_pulse2),
    .evt_valid (evt_valid2),
    .pend_cnt  (pend_cnt2),
    .overflow  (overflow2),
    .err_short (err_short2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives intr_in high for `high` edges then low for `low` edges; edge 1 is the
  // first edge sampling the high level. evt_ack is held across edge ack_edge.
  task automatic pulse(input int high, input int low, input int ack_edge,
                       output int np, output int pe, output int ne);
    np = 0; pe = 0; ne = 0;
    intr_in = 1'b1;
    for (int e = 1; e <= high + low; e++) begin
      if (e == high + 1) intr_in = 1'b0;
      if (e == ack_edge) evt_ack = 1'b1;
      tick();
      evt_ack = 1'b0;
      if (evt_pulse) begin
        np++;
        if (np == 1) pe = e;
      end
      if (err_short) ne++;
    end
  endtask

  task automatic ack_once();
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    intr_in = 1'b0; evt_ack = 1'b0; ovf_clr = 1'b0; evt_ack2 = 1'b0; ovf_clr2 = 1'b0;
    tick(); tick();
    check("rst_evt_pulse", 32'(evt_pulse), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_pend_cnt",  32'(pend_cnt),  0);
    check("rst_overflow",  32'(overflow),  0);
    check("rst_err_short", 32'(err_short), 0);
    rst_n = 1'b1;
    tick();

    // Single valid event: strobe after edge SYNC_STAGES+MIN_HIGH = 10.
    pulse(11, 11, 0, n_pulse, pulse_edge, n_err);
    check("single_n_pulse", 32'(n_pulse), 1);
    check("single_edge",    32'(pulse_edge), 10);
    check("single_n_err",   32'(n_err), 0);
    check("single_pend",    32'(pend_cnt), 1);
    check("single_valid",   32'(evt_valid), 1);
    ack_once();
    check("ack_to_zero_pend",  32'(pend_cnt), 0);
    check("ack_to_zero_valid", 32'(evt_valid), 0);

    // Short pulse: one error strobe, no event.
    pulse(3, 11, 0, n_pulse, pulse_edge, n_err);
    check("short_n_err",   32'(n_err), 1);
    check("short_n_pulse", 32'(n_pulse), 0);
    check("short_pend",    32'(pend_cnt), 0);

    // Two events queued, then drained; a third ack is ignored.
    pulse(11, 11, 0, n_pulse, pulse_edge, n_err);
    check("two_a_n_pulse", 32'(n_pulse), 1);
    pulse(11, 11, 0, n_pulse, pulse_edge, n_err);
    check("two_b_n_pulse", 32'(n_pulse), 1);
    check("two_pend",      32'(pend_cnt), 2);
    ack_once();
    check("drain1_pend", 32'(pend_cnt), 1);
    check("drain1_valid", 32'(evt_valid), 1);
    ack_once();
    check("drain2_pend",  32'(pend_cnt), 0);
    check("drain2_valid", 32'(evt_valid), 0);
    ack_once();
    check("extra_ack_pend",  32'(pend_cnt), 0);
    check("extra_ack_valid", 32'(evt_valid), 0);

    // Ack coinciding with acceptance leaves the count unchanged.
    pulse(11, 11, 0, n_pulse, pulse_edge, n_err);
    check("coinc_pre_pend", 32'(pend_cnt), 1);
    pulse(11, 11, 10, n_pulse, pulse_edge, n_err);
    check("coinc_n_pulse", 32'(n_pulse), 1);
    check("coinc_pend",    32'(pend_cnt), 1);
    check("coinc_valid",   32'(evt_valid), 1);
    ack_once();
    check("coinc_drain_pend", 32'(pend_cnt), 0);

    // Reset in HIGH_CHK with cnt=5 while the line stays high.
    intr_in = 1'b1;
    n_pulse = 0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (evt_pulse) n_pulse++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_no_pulse_before", 32'(n_pulse), 0);
    check("midrst_evt_pulse",       32'(evt_pulse), 0);
    check("midrst_err_short",       32'(err_short), 0);
    pulse(12, 11, 0, n_pulse, pulse_edge, n_err);
    check("midrst_n_pulse", 32'(n_pulse), 1);
    check("midrst_edge",    32'(pulse_edge), 10);
    check("midrst_n_err",   32'(n_err), 0);
    check("midrst_pend",    32'(pend_cnt), 1);

    // Saturation and overflow on the 2-bit pending counter.
    rst2_n = 1'b1;
    tick();
    for (int p = 1; p <= 5; p++) begin
      pulse(11, 11, 0, n_pulse, pulse_edge, n_err);
      if (p == 3) begin
        check("sat3_pend2",     32'(pend_cnt2), 3);
        check("sat3_overflow2", 32'(overflow2), 0);
      end
    end
    check("sat5_pend2",     32'(pend_cnt2), 3);
    check("sat5_overflow2", 32'(overflow2), 1);
    check("sat5_valid2",    32'(evt_valid2), 1);
    ovf_clr2 = 1'b1;
    tick();
    ovf_clr2 = 1'b0;
    check("clr_overflow2", 32'(overflow2), 0);
    check("clr_pend2",     32'(pend_cnt2), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
